serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking that sum and cout are valid.
REQ-010 sum  output  WIDTH  registered result, A+B+cin modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 The block SHALL compute with exactly one instance of the team's 1-bit fulladder cell (ports a, b, cin, s, c), with no other adder logic.
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: if start=1 at a clk edge, the block SHALL capture a and b into shift registers, load the carry register with cin, clear the bit counter, and enter RUN.
REQ-015 IDLE: if start=0, the block SHALL remain in IDLE with all output registers unchanged.
REQ-016 RUN: on each edge, the block SHALL feed operand LSBs and the carry register to the fulladder, shift the fulladder's s into the internal result shift register (LSB-first), load its c into the carry register, shift both operand registers right by one, and increment the counter.
REQ-017 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, the block SHALL enter DONE.
REQ-018 On that same edge, sum SHALL load the completed result and cout SHALL load the final carry; sum and cout SHALL not change at any other time except reset.
REQ-019 DONE SHALL last one cycle and then return unconditionally to IDLE.
REQ-020 busy SHALL be 1 exactly when state=RUN.
REQ-021 done SHALL be 1 exactly when state=DONE.
REQ-022 Latency: done SHALL rise on the WIDTH-th edge after the edge that accepted start, i.e. a new start is accepted no more often than every WIDTH+2 cycles.
REQ-023 start asserted in RUN or DONE SHALL be ignored, without queueing; a, b and cin changes outside acceptance SHALL have no effect.
REQ-024 start held high continuously SHALL launch a new addition on each IDLE cycle, i.e. back-to-back with one IDLE cycle between done and the next busy.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap during RUN.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force: state=IDLE, busy=0, done=0, sum=0, cout=0, and carry, counter and shift registers=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and sum/cout SHALL read 0.
REQ-028 After rst is released, the first start SHALL be accepted on the first clk edge at which rst is low.

Verification
REQ-029 The bench SHALL drive WIDTH=8, a=8'h00, b=8'h00, cin=0, start pulse -> busy high 8 cycles, done pulse on the 8th edge, sum=8'h00, cout=0.
REQ-030 The bench SHALL drive a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; a=8'h3C, b=8'h42, cin=1 -> sum=8'h7F, cout=0.
REQ-031 The bench SHALL pulse start again at RUN cycle 3 with different operands -> the first result is unaffected, there is exactly one done, and no second busy period.
REQ-032 The bench SHALL assert rst asynchronously at RUN cycle 4 -> busy, done, sum and cout are 0 before the next edge, and no done follows.
REQ-033 The bench SHALL hold start=1 with changing operands -> results arrive every 10 cycles, each matching the operands present at its acceptance edge.
REQ-034 The bench SHALL run an exhaustive or 1000-vector random sweep against the reference model a+b+cin -> {cout,sum} matches on every done.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first over
// WIDTH cycles, then presents a registered {cout,sum} with a one-cycle done.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);
  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  // Holds bits 0..WIDTH-2; the final bit joins straight from the cell.
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_c;
  logic             last_bit;

  fulladder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (fa_s),
    .c   (fa_c)
  );

  assign res_nxt  = {fa_s, res_sh};
  assign last_bit = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_nxt[WIDTH-1:1];
          carry  <= fa_c;
          // Stops at WIDTH-1, so the counter never reaches a wrap point.
          if (!last_bit) cnt <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= res_nxt;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One addition from IDLE; operands are scrambled right after acceptance.
  task automatic do_add(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W-1:0] es, input logic ec);
    int n, nb;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 0; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busy_cycles"}, nb, 8);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    @(posedge clk); #1;
    chk({tag, "_done_gone"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [8:0] expq[$];
    logic [8:0] ref_v;
    logic [W-1:0] ra, rb;
    logic rc, pbusy;
    int nd, nbsy, last;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_add("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    do_add("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_add("a55a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    do_add("3c42", 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0);

    // Idle with start low: outputs hold whatever inputs do.
    repeat (3) begin
      @(negedge clk); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    @(posedge clk); #1;
    chk("idle_hold_sum", sum, 8'h7F);
    chk("idle_hold_cout", cout, 0);

    // Second start pulse during RUN is dropped.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0; nbsy = 0;
    for (int k = 0; k < 16; k++) begin
      if (busy) nbsy++;
      if (done) begin
        nd++;
        chk("ign_sum", sum, 8'h46);
        chk("ign_cout", cout, 0);
      end
      if (k == 2) begin a = 8'hEE; b = 8'h77; cin = 1'b1; start = 1'b1; end
      if (k == 3) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("ign_done_count", nd, 1);
    chk("ign_busy_cycles", nbsy, 8);

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    a = 8'h81; b = 8'h81; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("abort_no_done", nd, 0);
    chk("abort_sum_stays", sum, 0);

    // First edge with rst low accepts start.
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rel_accept", busy, 1);
    repeat (9) @(posedge clk);
    #1;
    chk("rel_sum", sum, 8'h03);

    // start held high: new operands every cycle, one result per 10 cycles.
    @(negedge clk);
    start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    pbusy = 1'b0; nd = 0; last = -1;
    for (int cyc = 0; cyc < 46; cyc++) begin
      @(posedge clk); #1;
      if (busy && !pbusy) expq.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
      if (done) begin
        nd++;
        if (expq.size() == 0) chk("stream_queue", 0, 1);
        else chk("stream_res", {cout, sum}, expq.pop_front());
        if (last >= 0) chk("stream_period", cyc - last, 10);
        last = cyc;
      end
      pbusy = busy;
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
    chk("stream_count", nd, 4);
    nd = 0;
    for (int k = 0; k < 12 && nd == 0; k++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (expq.size() == 0) chk("stream_tail_queue", 0, 1);
        else chk("stream_tail", {cout, sum}, expq.pop_front());
      end
    end
    chk("stream_tail_seen", nd, 1);
    @(posedge clk); #1;

    // Random sweep against a+b+cin.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      do_add("rand", ra, rb, rc, ref_v[W-1:0], ref_v[W]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
